// File: rtl/cellram_wb_arbiter_pkg.sv
// Shared definitions for the two-master cellram Wishbone arbiter: bus widths,
// FSM state encoding and owner codes reported on mst_sel_o.
package cellram_wb_arbiter_pkg;

  localparam int ADR_W  = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_M0  = 2'd1,
    OWN_M1  = 2'd2,
    HOLDOFF = 2'd3
  } arb_state_t;

  localparam logic [1:0] MST_NONE = 2'b00;
  localparam logic [1:0] MST_M0   = 2'b01;
  localparam logic [1:0] MST_M1   = 2'b10;

  function automatic logic [1:0] owner_code(input arb_state_t s);
    case (s)
      OWN_M0:  owner_code = MST_M0;
      OWN_M1:  owner_code = MST_M1;
      default: owner_code = MST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cellram_wb_arbiter_if.sv
// Classic Wishbone bus bundle; the master modport drives the request side,
// the slave modport returns read data, ack and err.
interface cellram_wb_arbiter_if;
  import cellram_wb_arbiter_pkg::*;

  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] wdat;
  logic [SEL_W-1:0]  sel;
  logic              cyc;
  logic              stb;
  logic              we;
  logic [DATA_W-1:0] rdat;
  logic              ack;
  logic              err;

  modport master (output adr, wdat, sel, cyc, stb, we, input rdat, ack, err);
  modport slave  (input adr, wdat, sel, cyc, stb, we, output rdat, ack, err);

endinterface

// File: rtl/cellram_wb_arbiter_watchdog.sv
// Per-transfer ack watchdog: counts strobe cycles without ack and raises a
// one-cycle err when the limit is reached, then starts over.
module wb_ack_watchdog #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic ack,
  output logic err
);

  localparam logic [7:0] LAST = 8'(ACK_TIMEOUT - 1);

  logic [7:0] cnt;

  // An ack landing on the final counted cycle wins over the timeout.
  assign err = stb && !ack && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (!stb || ack || err) cnt <= '0;
    else                        cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/cellram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of cellram_ctrl: fixed priority to the
// video cache (m0) with an anti-starvation quota for the CPU port (m1).
module cellram_wb_arbiter
  import cellram_wb_arbiter_pkg::*;
#(
  parameter int MAX_M0_STREAK = 4,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  cellram_wb_arbiter_if.slave  m0,
  cellram_wb_arbiter_if.slave  m1,
  cellram_wb_arbiter_if.master s0,
  output logic [1:0]           mst_sel_o
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_M0_STREAK);

  arb_state_t state, state_nxt;
  logic [3:0] streak, streak_nxt;
  logic       m0_req, m1_req;
  logic       own_stb;
  logic       wd_err;

  assign m0_req = m0.cyc & m0.stb;
  assign m1_req = m1.cyc & m1.stb;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      streak    <= '0;
      mst_sel_o <= MST_NONE;
    end else begin
      state     <= state_nxt;
      streak    <= streak_nxt;
      mst_sel_o <= owner_code(state_nxt);
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    case (state)
      IDLE: begin
        if (m1_req && (!m0_req || streak == STREAK_MAX)) begin
          state_nxt  = OWN_M1;
          streak_nxt = '0;
        end else if (m0_req) begin
          state_nxt = OWN_M0;
          if (!m1_req)                 streak_nxt = '0;
          else if (streak != STREAK_MAX) streak_nxt = streak + 4'd1;
        end
      end
      OWN_M0:  if (!m0.cyc) state_nxt = HOLDOFF;
      OWN_M1:  if (!m1.cyc) state_nxt = HOLDOFF;
      default: state_nxt = IDLE;
    endcase
  end

  // A strobe without cyc is not a request, so it neither reaches the slave nor feeds the watchdog.
  always_comb begin
    case (state)
      OWN_M0:  own_stb = m0.cyc & m0.stb;
      OWN_M1:  own_stb = m1.cyc & m1.stb;
      default: own_stb = 1'b0;
    endcase
  end

  wb_ack_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_watchdog (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .stb   (own_stb),
    .ack   (s0.ack),
    .err   (wd_err)
  );

  always_comb begin
    s0.adr  = '0;
    s0.wdat = '0;
    s0.sel  = '0;
    s0.cyc  = 1'b0;
    s0.stb  = 1'b0;
    s0.we   = 1'b0;
    m0.rdat = '0;
    m0.ack  = 1'b0;
    m0.err  = 1'b0;
    m1.rdat = '0;
    m1.ack  = 1'b0;
    m1.err  = 1'b0;
    case (state)
      OWN_M0: begin
        s0.adr  = m0.adr;
        s0.wdat = m0.wdat;
        s0.sel  = m0.sel;
        s0.cyc  = m0.cyc;
        s0.we   = m0.we;
        s0.stb  = own_stb & ~wd_err;
        m0.rdat = s0.rdat;
        m0.ack  = s0.ack & own_stb;
        m0.err  = wd_err;
      end
      OWN_M1: begin
        s0.adr  = m1.adr;
        s0.wdat = m1.wdat;
        s0.sel  = m1.sel;
        s0.cyc  = m1.cyc;
        s0.we   = m1.we;
        s0.stb  = own_stb & ~wd_err;
        m1.rdat = s0.rdat;
        m1.ack  = s0.ack & own_stb;
        m1.err  = wd_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cellram_wb_arbiter.sv
// Self-checking bench for cellram_wb_arbiter: cycle table for ownership and
// holdoff, hand sequences for reset, streak quota and watchdog, ack scoreboard.
module tb_cellram_wb_arbiter;
  import cellram_wb_arbiter_pkg::*;

  localparam logic [31:0] M0_ADR  = 32'h0000_0100;
  localparam logic [31:0] M0_WD   = 32'hAAAA_5555;
  localparam logic [31:0] M1_ADR  = 32'h0000_0200;
  localparam logic [31:0] M1_WD   = 32'h1234_5678;
  localparam logic [31:0] SLV_DAT = 32'hCAFE_0001;

  typedef struct packed {
    logic        who;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic       c0, t0, c1, t1, ack;
    logic [1:0] sel;
    logic       cyc, stb, a0, a1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mst_sel;
  int         n_run = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  vec_t       vt[11];
  int         n_m0;

  cellram_wb_arbiter_if m0_bus ();
  cellram_wb_arbiter_if m1_bus ();
  cellram_wb_arbiter_if s0_bus ();

  cellram_wb_arbiter #(
    .MAX_M0_STREAK (4),
    .ACK_TIMEOUT   (8)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m0         (m0_bus),
    .m1         (m1_bus),
    .s0         (s0_bus),
    .mst_sel_o  (mst_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) next_drive();
  endtask

  task automatic drv_m0(input logic c, input logic s);
    m0_bus.cyc = c;
    m0_bus.stb = s;
  endtask

  task automatic drv_m1(input logic c, input logic s);
    m1_bus.cyc = c;
    m1_bus.stb = s;
  endtask

  task automatic drv_slv(input logic a, input logic [31:0] d);
    s0_bus.ack  = a;
    s0_bus.rdat = d;
  endtask

  function automatic vec_t mkv(input logic [4:0] stim, input logic [1:0] sel, input logic [3:0] out);
    vec_t v;
    {v.c0, v.t0, v.c1, v.t1, v.ack} = stim;
    v.sel = sel;
    {v.cyc, v.stb, v.a0, v.a1} = out;
    return v;
  endfunction

  function automatic logic [68:0] exp_bus(input logic [1:0] sel);
    case (sel)
      MST_M0:  return {1'b0, 4'hF, M0_ADR, M0_WD};
      MST_M1:  return {1'b1, 4'b0011, M1_ADR, M1_WD};
      default: return '0;
    endcase
  endfunction

  // Both masters keep asking; m0 re-requests after each transfer until m1 gets in.
  task automatic run_streak(input string tag, output int n_grants);
    bit         got_m1;
    bit         timeout;
    logic [1:0] owner;
    logic [31:0] d;
    got_m1   = 1'b0;
    timeout  = 1'b0;
    n_grants = 0;
    next_drive();
    drv_m0(1'b1, 1'b1);
    drv_m1(1'b1, 1'b1);
    for (int g = 0; g < 8 && !got_m1 && !timeout; g++) begin
      owner = MST_NONE;
      for (int k = 0; k < 6 && owner == MST_NONE; k++) begin
        @(negedge clk);
        owner = mst_sel;
      end
      if (owner == MST_NONE) begin
        timeout = 1'b1;
      end else begin
        d = 32'h5000_0000 + 32'(g);
        next_drive();
        drv_slv(1'b1, d);
        sb.push_back(exp_t'{who: (owner == MST_M1), dat: d});
        next_drive();
        drv_slv(1'b0, '0);
        if (owner == MST_M1) begin
          got_m1 = 1'b1;
          drv_m0(1'b0, 1'b0);
          drv_m1(1'b0, 1'b0);
        end else begin
          n_grants++;
          drv_m0(1'b0, 1'b0);
          next_drive();
          drv_m0(1'b1, 1'b1);
        end
      end
    end
    check({tag, "_grant_wait_expired"}, {95'd0, timeout}, 96'd0);
    drv_m0(1'b0, 1'b0);
    drv_m1(1'b0, 1'b0);
    idle_cycles(3);
  endtask

  // Ack scoreboard: every ack a master sees must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m0_bus.ack || m1_bus.ack) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_ack", {94'd0, m1_bus.ack, m0_bus.ack}, 96'd0);
        end else begin
          e = sb.pop_front();
          check("sb_ack_owner", {94'd0, m1_bus.ack, m0_bus.ack}, e.who ? 96'd2 : 96'd1);
          check("sb_rdat", e.who ? m1_bus.rdat : m0_bus.rdat, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    vt[0]  = mkv(5'b00110, 2'd0, 4'b0000);
    vt[1]  = mkv(5'b00110, 2'd2, 4'b1100);
    vt[2]  = mkv(5'b00111, 2'd2, 4'b1101);
    vt[3]  = mkv(5'b00000, 2'd2, 4'b0000);
    vt[4]  = mkv(5'b11000, 2'd0, 4'b0000);
    vt[5]  = mkv(5'b11000, 2'd0, 4'b0000);
    vt[6]  = mkv(5'b11000, 2'd1, 4'b1100);
    vt[7]  = mkv(5'b01000, 2'd1, 4'b0000);
    vt[8]  = mkv(5'b01001, 2'd0, 4'b0000);
    vt[9]  = mkv(5'b00001, 2'd0, 4'b0000);
    vt[10] = mkv(5'b00000, 2'd0, 4'b0000);

    rst_n = 1'b0;
    m0_bus.adr = M0_ADR; m0_bus.wdat = M0_WD; m0_bus.sel = 4'hF;    m0_bus.we = 1'b0;
    m1_bus.adr = M1_ADR; m1_bus.wdat = M1_WD; m1_bus.sel = 4'b0011; m1_bus.we = 1'b1;
    drv_m0(1'b0, 1'b0);
    drv_m1(1'b0, 1'b0);
    drv_slv(1'b0, '0);
    s0_bus.err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mst_sel", mst_sel, MST_NONE);
    check("rst_s0_cyc_stb", {s0_bus.cyc, s0_bus.stb}, 0);
    check("rst_ack_err", {m1_bus.ack, m0_bus.ack, m1_bus.err, m0_bus.err}, 0);
    next_drive();
    rst_n = 1'b1;

    // m0 read alone, slave answers four cycles into the grant
    next_drive();
    m0_bus.adr = 32'h00F8_0000;
    drv_m0(1'b1, 1'b1);
    sb.push_back(exp_t'{who: 1'b0, dat: 32'hDEAD_BEEF});
    @(negedge clk);
    check("t2_request_cycle_stb", s0_bus.stb, 0);
    @(negedge clk);
    check("t2_grant_stb", s0_bus.stb, 1);
    check("t2_grant_adr", s0_bus.adr, 32'h00F8_0000);
    check("t2_grant_sel", mst_sel, MST_M0);
    for (int k = 0; k < 3; k++) begin
      next_drive();
      @(negedge clk);
      check($sformatf("t2_no_ack_%0d", k), {m1_bus.ack, m0_bus.ack}, 0);
    end
    next_drive();
    drv_slv(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t2_ack", {m1_bus.ack, m0_bus.ack}, 2'b01);
    check("t2_m1_rdat_zero", m1_bus.rdat, 0);
    next_drive();
    drv_slv(1'b0, '0);
    drv_m0(1'b0, 1'b0);
    m0_bus.adr = M0_ADR;
    idle_cycles(3);

    // reset asserted in the middle of an m0 read
    next_drive();
    drv_m0(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t1_granted_before_reset", mst_sel, MST_M0);
    #2;
    rst_n = 1'b0;
    drv_slv(1'b1, 32'h5A5A_5A5A);
    #1;
    check("t1_rst_s0_cyc_stb", {s0_bus.cyc, s0_bus.stb}, 0);
    check("t1_rst_mst_sel", mst_sel, MST_NONE);
    check("t1_rst_acks", {m1_bus.ack, m0_bus.ack}, 0);
    next_drive();
    drv_m0(1'b0, 1'b0);
    drv_slv(1'b0, '0);
    rst_n = 1'b1;
    idle_cycles(3);

    // streak quota, twice: the second run only sees 4 m0 grants if the streak was cleared
    run_streak("t3a", n_m0);
    check("t3_m0_grants_before_m1", n_m0, 4);
    run_streak("t3b", n_m0);
    check("t3_streak_cleared", n_m0, 4);

    // m1 write, holdoff, m0 grant, m0 drops cyc with stb high, stray acks
    for (int i = 0; i < 11; i++) begin
      next_drive();
      drv_m0(vt[i].c0, vt[i].t0);
      drv_m1(vt[i].c1, vt[i].t1);
      drv_slv(vt[i].ack, vt[i].ack ? SLV_DAT : 32'd0);
      if (vt[i].a0) sb.push_back(exp_t'{who: 1'b0, dat: SLV_DAT});
      if (vt[i].a1) sb.push_back(exp_t'{who: 1'b1, dat: SLV_DAT});
      @(negedge clk);
      check($sformatf("vec%0d_mst_sel", i), mst_sel, vt[i].sel);
      check($sformatf("vec%0d_cyc_stb", i), {s0_bus.cyc, s0_bus.stb}, {vt[i].cyc, vt[i].stb});
      check($sformatf("vec%0d_ack_err", i),
            {m1_bus.ack, m0_bus.ack, m1_bus.err, m0_bus.err}, {vt[i].a1, vt[i].a0, 2'b00});
      check($sformatf("vec%0d_bus", i),
            {s0_bus.we, s0_bus.sel, s0_bus.adr, s0_bus.wdat}, exp_bus(vt[i].sel));
    end
    idle_cycles(2);

    // watchdog: m1 never acked, err on the 8th strobe cycle, then counting restarts
    next_drive();
    drv_m1(1'b1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      next_drive();
      @(negedge clk);
      check($sformatf("t5_err_cycle%0d", k), {m1_bus.err, m0_bus.err}, (k == 8) ? 2'b10 : 2'b00);
      check($sformatf("t5_stb_cycle%0d", k), s0_bus.stb, (k == 8) ? 96'd0 : 96'd1);
    end
    next_drive();
    drv_m1(1'b0, 1'b0);
    idle_cycles(3);

    // watchdog: ack arriving on the 8th strobe cycle beats the timeout
    next_drive();
    drv_m0(1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      next_drive();
      if (k == 8) begin
        drv_slv(1'b1, 32'h0BAD_F00D);
        sb.push_back(exp_t'{who: 1'b0, dat: 32'h0BAD_F00D});
      end
      @(negedge clk);
      if (k == 8) begin
        check("t5_ack_wins_err", {m1_bus.err, m0_bus.err}, 0);
        check("t5_ack_wins_ack", {m1_bus.ack, m0_bus.ack}, 2'b01);
        check("t5_ack_wins_stb", s0_bus.stb, 1);
      end
    end
    next_drive();
    drv_slv(1'b0, '0);
    drv_m0(1'b0, 1'b0);
    idle_cycles(3);

    check("sb_all_acks_seen", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
